// File: rtl/substitution_layer.sv
// Ascon substitution layer: the 5-bit S-box is applied to all 64 bit-slices of the
// 320-bit state. The block has a combinational output and a registered copy with a valid flag.
package ascon_pkg;
  parameter int WORD_WIDTH = 64;
  typedef logic [WORD_WIDTH-1:0] ascon_state_t [0:4];
endpackage

module substitution_layer
  import ascon_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  ascon_state_t state_array_i,
  output ascon_state_t state_array_o,
  output ascon_state_t state_reg_o,
  output logic         valid_o
);

  // Word-wide bitwise ops evaluate all 64 slices in parallel; no data-dependent paths.
  function automatic ascon_state_t sbox_layer(input ascon_state_t s);
    ascon_state_t y;
    logic [WORD_WIDTH-1:0] x0, x1, x2, x3, x4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2];
    x3 = s[3];
    x4 = s[4];
    y[0] = (x4 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ (x1 & x0) ^ x1 ^ x0;
    y[1] = x4 ^ (x3 & x2) ^ (x3 & x1) ^ x3 ^ (x2 & x1) ^ x2 ^ x1 ^ x0;
    y[2] = ~((x4 & x3) ^ x4 ^ x2 ^ x1);
    y[3] = (x4 & x0) ^ x4 ^ (x3 & x0) ^ x3 ^ x2 ^ x1 ^ x0;
    y[4] = (x4 & x1) ^ x4 ^ x3 ^ (x1 & x0) ^ x1;
    return y;
  endfunction

  ascon_state_t sbox_out;
  ascon_state_t state_reg_d, state_reg_q;
  logic         valid_d, valid_q;

  always_comb begin
    sbox_out = sbox_layer(state_array_i);
  end

  always_comb begin
    state_reg_d = state_reg_q;
    valid_d     = valid_i;
    if (valid_i) begin
      state_reg_d = sbox_out;
    end
  end

  // Registered stage: the result holds while valid_i is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg_q <= '{default: '0};
      valid_q     <= 1'b0;
    end else begin
      state_reg_q <= state_reg_d;
      valid_q     <= valid_d;
    end
  end

  assign state_array_o = sbox_out;
  assign state_reg_o   = state_reg_q;
  assign valid_o       = valid_q;

endmodule

// File: tb/tb_substitution_layer.sv
// Self-checking bench for substitution_layer. The reference model gathers each bit-slice into an
// index and looks it up in the published S-box table.
module tb_substitution_layer;
  import ascon_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  ascon_state_t state_array_i;
  ascon_state_t state_array_o;
  ascon_state_t state_reg_o;
  logic         valid_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

  substitution_layer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .state_array_i (state_array_i),
    .state_array_o (state_array_o),
    .state_reg_o   (state_reg_o),
    .valid_o       (valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [319:0] flat(input ascon_state_t s);
    return {s[0], s[1], s[2], s[3], s[4]};
  endfunction

  function automatic ascon_state_t ref_sbox(input ascon_state_t s);
    ascon_state_t r;
    logic [4:0] idx;
    logic [4:0] v;
    for (int j = 0; j < WORD_WIDTH; j++) begin
      idx = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      v   = SBOX[idx];
      for (int k = 0; k < 5; k++) r[k][j] = v[4-k];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ascon_state_t rand_state();
    ascon_state_t s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  ascon_state_t zero_st, ones_st, st, held;
  logic [319:0] exp_reg;
  logic         exp_vld;

  initial begin
    zero_st = '{default: '0};
    ones_st = '{default: '1};
    rst_i = 1'b1;
    valid_i = 1'b0;
    state_array_i = zero_st;
    #1;
    check("reset_valid", 320'(valid_o), 320'(0));
    check("reset_reg", flat(state_reg_o), 320'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    // Truth-table sweep on slice 0.
    for (int x = 0; x < 32; x++) begin
      st = zero_st;
      for (int k = 0; k < 5; k++) st[k][0] = x[4-k];
      state_array_i = st;
      #1;
      check($sformatf("tt_slice0_%0d", x),
            320'({state_array_o[0][0], state_array_o[1][0], state_array_o[2][0],
                  state_array_o[3][0], state_array_o[4][0]}),
            320'(SBOX[x]));
      check($sformatf("tt_state_%0d", x), flat(state_array_o), flat(ref_sbox(st)));
    end

    state_array_i = zero_st;
    #1;
    check("all_zero", flat(state_array_o),
          {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});
    state_array_i = ones_st;
    #1;
    check("all_ones", flat(state_array_o),
          {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF});

    for (int i = 0; i < 500; i++) begin
      st = rand_state();
      state_array_i = st;
      #1;
      check("random_comb", flat(state_array_o), flat(ref_sbox(st)));
    end

    // Registered path: a single valid all-zero state, then hold.
    @(negedge clk_i);
    valid_i = 1'b1;
    state_array_i = zero_st;
    @(posedge clk_i);
    #1;
    check("reg_valid_hi", 320'(valid_o), 320'(1));
    check("reg_zero_s2", flat(state_reg_o),
          {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});
    @(negedge clk_i);
    valid_i = 1'b0;
    state_array_i = rand_state();
    @(posedge clk_i);
    #1;
    check("reg_valid_lo", 320'(valid_o), 320'(0));
    check("reg_hold", flat(state_reg_o),
          {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0});

    // Random streaming with a cycle-level scoreboard.
    exp_reg = flat(state_reg_o);
    exp_reg = {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      st = rand_state();
      state_array_i = st;
      valid_i = ($urandom_range(0, 3) != 0);
      exp_vld = valid_i;
      if (valid_i) exp_reg = flat(ref_sbox(st));
      @(posedge clk_i);
      #1;
      check("stream_valid", 320'(valid_o), 320'(exp_vld));
      check("stream_reg", flat(state_reg_o), exp_reg);
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    @(negedge clk_i);
    valid_i = 1'b1;
    st = ones_st;
    state_array_i = st;
    @(posedge clk_i);
    #1;
    check("pre_rst_valid", 320'(valid_o), 320'(1));
    #1;
    rst_i = 1'b1;
    #1;
    check("async_rst_valid", 320'(valid_o), 320'(0));
    check("async_rst_reg", flat(state_reg_o), 320'(0));
    st = rand_state();
    state_array_i = st;
    #1;
    check("rst_comb_tracks", flat(state_array_o), flat(ref_sbox(st)));
    @(posedge clk_i);
    #1;
    check("rst_held_valid", 320'(valid_o), 320'(0));
    check("rst_held_reg", flat(state_reg_o), 320'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    st = rand_state();
    state_array_i = st;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_valid", 320'(valid_o), 320'(1));
    check("post_rst_reg", flat(state_reg_o), flat(ref_sbox(st)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
